// File: rtl/gt_rx_block_sync.sv
// gt_rx_block_sync
// 64B/66B receive block-alignment stage for one GT channel. It hunts for
// 66-bit block alignment by pulsing the channel gearbox slip input. It
// declares lock after SH_CNT_MAX consecutive valid sync headers. While
// locked it watches windows of SH_CNT_MAX headers and drops lock when
// SH_INVALID_MAX invalid headers land in one window. Data and headers are
// forwarded with one cycle of latency, and valid is gated by lock.
//
// Ports:
//   i_rx_clk          channel RX user clock (rising edge)
//   i_rx_reset        synchronous active-high reset
//   i_rx_data         channel rxdata
//   i_rx_datavalid    channel rxdatavalid
//   i_rx_header       channel rxheader
//   i_rx_headervalid  channel rxheadervalid; headers are evaluated only when set
//   o_rx_gearboxslip  one-cycle slip pulse to rxgearboxslip
//   o_block_lock      block alignment achieved
//   o_rx_data         registered aligned data
//   o_rx_header       registered aligned header
//   o_rx_valid        registered data valid, gated by lock
//   o_slip_cnt        slips since reset, saturating
module gt_rx_block_sync #(
  parameter int unsigned SH_CNT_MAX     = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT      = 32
) (
  input  logic        i_rx_clk,
  input  logic        i_rx_reset,
  input  logic [63:0] i_rx_data,
  input  logic        i_rx_datavalid,
  input  logic [1:0]  i_rx_header,
  input  logic        i_rx_headervalid,
  output logic        o_rx_gearboxslip,
  output logic        o_block_lock,
  output logic [63:0] o_rx_data,
  output logic [1:0]  o_rx_header,
  output logic        o_rx_valid,
  output logic [15:0] o_slip_cnt
);

  localparam int unsigned SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]        slip_cnt_q, slip_cnt_d;
  logic [63:0]        data_q;
  logic [1:0]         hdr_q;
  logic               valid_q;
  logic               hdr_ok;

  // Sync header is valid only for 01 or 10.
  assign hdr_ok = i_rx_header[1] ^ i_rx_header[0];

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_cnt_d = slip_cnt_q;
    unique case (state_q)
      ST_HUNT: begin
        if (i_rx_headervalid) begin
          if (hdr_ok) begin
            if (sh_cnt_q == SH_W'(SH_CNT_MAX - 1)) begin
              state_d   = ST_LOCKED;
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_q + SH_W'(1);
            end
          end else begin
            state_d    = ST_SLIP;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
            if (slip_cnt_q != '1) slip_cnt_d = slip_cnt_q + 16'd1;
          end
        end
      end
      // The settle window is counted from the slip pulse itself: the SLIP
      // cycle plus SLIP_WAIT-1 WAIT cycles. This gives a slip-to-slip
      // period of SLIP_WAIT+1 when headers stay invalid.
      ST_SLIP: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
          state_d    = ST_HUNT;
          sh_cnt_d   = '0;
          inv_cnt_d  = '0;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (i_rx_headervalid) begin
          // Loss of lock takes precedence over the window end.
          if (!hdr_ok && inv_cnt_q == INV_W'(SH_INVALID_MAX - 1)) begin
            state_d    = ST_SLIP;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
            if (slip_cnt_q != '1) slip_cnt_d = slip_cnt_q + 16'd1;
          end else if (sh_cnt_q == SH_W'(SH_CNT_MAX - 1)) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
            if (!hdr_ok) inv_cnt_d = inv_cnt_q + INV_W'(1);
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rx_reset) begin
      state_q    <= ST_HUNT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_cnt_q <= '0;
      data_q     <= '0;
      hdr_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      data_q     <= i_rx_data;
      hdr_q      <= i_rx_header;
      valid_q    <= i_rx_datavalid & (state_q == ST_LOCKED);
    end
  end

  assign o_rx_gearboxslip = (state_q == ST_SLIP);
  assign o_block_lock     = (state_q == ST_LOCKED);
  assign o_rx_data        = data_q;
  assign o_rx_header      = hdr_q;
  assign o_rx_valid       = valid_q;
  assign o_slip_cnt       = slip_cnt_q;

endmodule

// File: tb/tb_gt_rx_block_sync.sv
// Testbench for gt_rx_block_sync: directed vectors, a reference model of
// the alignment rules, and literal checks at key points.
module tb_gt_rx_block_sync;

  localparam int SH_MAX   = 64;
  localparam int INV_MAX  = 16;
  localparam int SETTLE   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] d_in;
  logic        dv_in;
  logic [1:0]  h_in;
  logic        hv_in;
  logic        slip_o, lock_o, valid_o;
  logic [63:0] data_o;
  logic [1:0]  hdr_o;
  logic [15:0] slipcnt_o;

  always #5 clk = ~clk;

  gt_rx_block_sync #(
    .SH_CNT_MAX(64),
    .SH_INVALID_MAX(16),
    .SLIP_WAIT(32)
  ) dut (
    .i_rx_clk(clk),
    .i_rx_reset(rst),
    .i_rx_data(d_in),
    .i_rx_datavalid(dv_in),
    .i_rx_header(h_in),
    .i_rx_headervalid(hv_in),
    .o_rx_gearboxslip(slip_o),
    .o_block_lock(lock_o),
    .o_rx_data(data_o),
    .o_rx_header(hdr_o),
    .o_rx_valid(valid_o),
    .o_slip_cnt(slipcnt_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a countdown of ignored header edges after a slip,
  // a run length while hunting, and window tallies while locked.
  bit          model_on = 1'b0;
  bit          m_locked;
  int          m_blind, m_run, m_win, m_bad;
  logic [15:0] m_slips;
  logic        e_slip, e_lock, e_valid;
  logic [63:0] e_data;
  logic [1:0]  e_hdr;
  bit          good;
  bit          start_slip;

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      m_locked = 1'b0; m_blind = 0; m_run = 0; m_win = 0; m_bad = 0;
      m_slips = '0;
      e_slip = 1'b0; e_lock = 1'b0; e_valid = 1'b0; e_data = '0; e_hdr = '0;
    end else if (model_on) begin
      e_data  = d_in;
      e_hdr   = h_in;
      e_valid = dv_in && m_locked;
      e_slip  = 1'b0;
      start_slip = 1'b0;
      good = (h_in == 2'b01) || (h_in == 2'b10);
      if (m_blind > 0) begin
        m_blind--;
      end else if (m_locked) begin
        if (hv_in) begin
          m_win++;
          if (!good) m_bad++;
          if (m_bad == INV_MAX) begin
            m_locked = 1'b0;
            start_slip = 1'b1;
          end else if (m_win == SH_MAX) begin
            m_win = 0; m_bad = 0;
          end
        end
      end else if (hv_in) begin
        if (good) begin
          m_run++;
          if (m_run == SH_MAX) begin
            m_locked = 1'b1; m_run = 0; m_win = 0; m_bad = 0;
          end
        end else begin
          start_slip = 1'b1;
        end
      end
      if (start_slip) begin
        e_slip = 1'b1;
        if (m_slips != 16'hFFFF) m_slips++;
        m_blind = SETTLE;
        m_run = 0; m_win = 0; m_bad = 0;
      end
      e_lock = m_locked;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("slip",    {63'd0, slip_o},  {63'd0, e_slip});
      chk("lock",    {63'd0, lock_o},  {63'd0, e_lock});
      chk("valid",   {63'd0, valid_o}, {63'd0, e_valid});
      chk("data",    data_o,           e_data);
      chk("hdr",     {62'd0, hdr_o},   {62'd0, e_hdr});
      chk("slipcnt", {48'd0, slipcnt_o}, {48'd0, m_slips});
    end
  end

  task automatic step(input logic r, input logic hv, input logic [1:0] h,
                      input logic dv, input logic [63:0] d);
    @(negedge clk);
    rst = r; hv_in = hv; h_in = h; dv_in = dv; d_in = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 2'b10, 1'b1, 64'hDEAD_BEEF_0000_0001);
    step(1'b1, 1'b1, 2'b10, 1'b1, 64'hDEAD_BEEF_0000_0002);
  endtask

  task automatic valid_hdrs(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 2'b01, 1'b1, 64'(i) * 64'h0101_0101_0101_0101);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_slip0"},  {63'd0, slip_o},   64'd0);
    chk({tag, "_lock0"},  {63'd0, lock_o},   64'd0);
    chk({tag, "_valid0"}, {63'd0, valid_o},  64'd0);
    chk({tag, "_data0"},  data_o,            64'd0);
    chk({tag, "_hdr0"},   {62'd0, hdr_o},    64'd0);
    chk({tag, "_cnt0"},   {48'd0, slipcnt_o}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; hv_in = 1'b0; h_in = 2'b00; dv_in = 1'b0; d_in = '0;

    // Clean acquisition with 70 valid headers
    do_reset();
    after_edge();
    check_all_zero("rst");
    valid_hdrs(63);
    after_edge();
    chk("t1_lock_after63", {63'd0, lock_o}, 64'd0);
    valid_hdrs(1);
    after_edge();
    chk("t1_lock_after64", {63'd0, lock_o}, 64'd1);
    chk("t1_valid_on_lock_cycle", {63'd0, valid_o}, 64'd0);
    valid_hdrs(6);
    after_edge();
    chk("t1_valid_locked", {63'd0, valid_o}, 64'd1);
    chk("t1_slipcnt", {48'd0, slipcnt_o}, 64'd0);

    // Single bad header at #10 while hunting
    do_reset();
    valid_hdrs(9);
    step(1'b0, 1'b1, 2'b11, 1'b1, 64'h1111);
    after_edge();
    chk("t2_slip_pulse", {63'd0, slip_o}, 64'd1);
    chk("t2_slipcnt1", {48'd0, slipcnt_o}, 64'd1);
    valid_hdrs(1);
    after_edge();
    chk("t2_slip_one_cycle", {63'd0, slip_o}, 64'd0);
    valid_hdrs(SETTLE - 1);
    valid_hdrs(63);
    after_edge();
    chk("t2_lock_after63", {63'd0, lock_o}, 64'd0);
    valid_hdrs(1);
    after_edge();
    chk("t2_lock_after64", {63'd0, lock_o}, 64'd1);

    // Invalid headers while locked: 15 held, 16 lost
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 2'b00, 1'b1, 64'h2222);
    valid_hdrs(49);
    after_edge();
    chk("t3_lock_15bad", {63'd0, lock_o}, 64'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 2'b11, 1'b1, 64'h3333);
    after_edge();
    chk("t3_lock_w2_15bad", {63'd0, lock_o}, 64'd1);
    step(1'b0, 1'b1, 2'b00, 1'b1, 64'h4444);
    after_edge();
    chk("t3_lost_lock", {63'd0, lock_o}, 64'd0);
    chk("t3_slip_pulse", {63'd0, slip_o}, 64'd1);
    chk("t3_slipcnt2", {48'd0, slipcnt_o}, 64'd2);
    valid_hdrs(40);

    // Constant invalid headers for 1000 cycles
    do_reset();
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 2'b00, 1'b0, 64'(i));
    after_edge();
    chk("t4_slipcnt31", {48'd0, slipcnt_o}, 64'd31);
    chk("t4_nolock", {63'd0, lock_o}, 64'd0);

    // Datapath before and after lock, headervalid gaps
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b11, 1'b1, 64'hCAFE_0000_0000_0000 + 64'(i));
    after_edge();
    chk("t5_no_slip_hv0", {63'd0, slip_o}, 64'd0);
    chk("t5_valid_prelock", {63'd0, valid_o}, 64'd0);
    chk("t5_data_prelock", data_o, 64'hCAFE_0000_0000_0004);
    valid_hdrs(64);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'(i % 3 != 0), (i % 5 == 0) ? 2'b11 : 2'b10, 1'(i % 2),
           64'h5A5A_0000_0000_0000 ^ 64'(i * 7));
    after_edge();
    chk("t5_valid_locked", {63'd0, valid_o}, 64'd1);
    chk("t5_data_locked", data_o, 64'h5A5A_0000_0000_0000 ^ 64'd133);

    // Reset during WAIT, then during LOCKED
    do_reset();
    valid_hdrs(5);
    step(1'b0, 1'b1, 2'b00, 1'b1, 64'h7);
    valid_hdrs(10);
    step(1'b1, 1'b1, 2'b10, 1'b1, 64'hFFFF_0000_FFFF_0000);
    after_edge();
    check_all_zero("t6_wait");
    valid_hdrs(63);
    after_edge();
    chk("t6_relock63", {63'd0, lock_o}, 64'd0);
    valid_hdrs(1);
    after_edge();
    chk("t6_relock64", {63'd0, lock_o}, 64'd1);
    step(1'b1, 1'b1, 2'b01, 1'b1, 64'h0123_4567_89AB_CDEF);
    after_edge();
    check_all_zero("t6_locked");
    valid_hdrs(63);
    after_edge();
    chk("t6_relock2_63", {63'd0, lock_o}, 64'd0);
    valid_hdrs(1);
    after_edge();
    chk("t6_relock2_64", {63'd0, lock_o}, 64'd1);
    valid_hdrs(3);
    after_edge();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
